rv32im_instr_encoder: RTL
=========================

# rv32im_instr_encoder

Encodes one RV32IM instruction request (`instr_type` mnemonic, register indices, signed immediate) into a 32-bit machine word. It is the inverse of the instruction classification carried by `risc_pkg`. It sits between the instruction agent's stimulus sequencer and the instruction-memory loader / DUT fetch driver. Requests enter through a valid/ready handshake and are encoded combinationally. Results are buffered in a 2-entry output queue with its own valid/ready handshake. Illegal requests are flagged rather than dropped.

## Interface
- No parameters; all opcode, funct3 and enum values come from `risc_pkg`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept; high iff the queue holds fewer than 2 entries.
- `in_type`  in  6  `risc_pkg::instr_type`.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices; fields unused by the format are ignored.
- `in_imm`  in  32  signed immediate, byte offset for branches and jumps.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_instr`  out  32  encoded word at queue head.
- `out_illegal`  out  1  head request was illegal; `out_instr` is 0x00000000 in that case.
- `instr_count`  out  32  number of output handshakes; wraps modulo 2^32.
- `illegal_count`  out  16  number of illegal entries output; saturates at 0xFFFF.

## Operation
- **Accept.** A request is accepted when `in_valid && in_ready` at a rising edge. The encoded word and illegal flag are written to the queue tail.
- **Pop.** An output handshake occurs when `out_valid && out_ready`. It pops the head and updates both counters.
- **Field layout.**
  - R-type: funct7 in [31:25], rs2 in [24:20], rs1 in [19:15], funct3 in [14:12], rd in [11:7], opcode in [6:0].
  - funct7 is 0x01 for MUL..REMU, 0x20 for SUB and SRA, and 0x00 otherwise.
- **I-type** (ADDI..ANDI, LB..LHU, JALR):
  - Immediate goes to imm[11:0] in [31:20].
  - Legal range is -2048..2047.
  - SLLI/SRLI/SRAI use imm 0..31 in [24:20]. [31:25] is 0x00, or 0x20 for SRAI.
- **S-type:** imm[11:5] in [31:25], imm[4:0] in [11:7]. Legal range is -2048..2047.
- **B-type:** imm[12|10:5] in [31:25], imm[4:1|11] in [11:8|7]. The immediate must be even and in -4096..4094.
- **U-type (LUI, AUIPC):** imm[31:12] in [31:12]. in_imm[11:0] must be 0.
- **J-type (JAL):** imm[20|10:1|11|19:12] in [31:12]. The immediate must be even and in -1048576..1048574.
- **RESET type:** encodes the canonical NOP, 0x00000013, which is legal.
- **Illegal requests:** UNKNOWN, any undefined enum code, or any immediate range/alignment violation. The queue stores word 0x00000000 with illegal=1.
- **Queue.** 2-entry FIFO with head/tail pointers and an occupancy counter 0..2. Order is preserved.
- **Simultaneous push and pop** at occupancy 1: the occupancy stays 1, the new entry becomes the head on the next cycle, and no data is lost.
- **Full** (occupancy 2): `in_ready` is 0. `in_ready` depends only on registered occupancy, with no combinational path from `out_ready`.
- **Empty:** `out_valid` is 0. `out_instr` and `out_illegal` are 0.

## Timing
- **Reset** (`rst` high at an edge): occupancy is 0, pointers are 0, and `instr_count` and `illegal_count` are 0. On the following cycle:
  - `out_valid` is 0;
  - `out_instr` is 0x00000000;
  - `out_illegal` is 0;
  - `in_ready` is 1.
- Reset overrides any handshake in the same cycle.
- **Latency:** a request accepted at edge N appears at the head with `out_valid` 1 after edge N if the queue was empty before it. Otherwise it appears after the older entries drain.
- **Throughput:** one instruction per cycle when `out_ready` is held high.
- **Counters:** update at the same edge as the output handshake.
- **Output stability:** `out_instr` and `out_illegal` are stable while `out_valid && !out_ready`.

## Test plan
- **Reset mid-stream.** Apply `rst` with 2 entries queued. Next cycle: `out_valid`=0, `in_ready`=1, both counts 0.
- **Encoding sweep.** With `out_ready`=1, send each request below. Each word emerges 1 cycle after accept, illegal=0, and `instr_count` ends at 7.
  - ADD x3,x1,x2 → 0x002081B3
  - MUL x3,x1,x2 → 0x022081B3
  - ADDI x1,x0,-1 → 0xFFF00093
  - SW x2,8(x1) → 0x0020A423
  - BEQ x1,x2,+8 → 0x00208463
  - JAL x1,+2048 → 0x001000EF
  - LUI x5,0x12345000 → 0x123452B7
- **Backpressure.** Hold `out_ready`=0 and offer 3 requests. The first 2 are accepted and `in_ready` drops. Release `out_ready`: outputs arrive in order, and the 3rd request is accepted the cycle after the first pop.
- **Simultaneous push/pop at occupancy 1.** Order is kept, with no duplicate or loss.
- **Illegal requests.** Send ADDI imm=2048, BEQ imm=3, LUI imm=0x1, and UNKNOWN. Each yields `out_instr`=0x00000000 with `out_illegal`=1, and `illegal_count` reaches 4.
- **Saturation and wrap.** Force `illegal_count` to 0xFFFF and `instr_count` to 0xFFFFFFFF, then send one illegal request. Result: `illegal_count` stays 0xFFFF and `instr_count` reads 0.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg
// Shared RV32IM definitions: the instruction mnemonic enum carried on the
// 6-bit instr_type field, the base opcodes, the canonical NOP word and
// the funct3 lookup that the encoder uses.
package risc_pkg;

  typedef enum logic [5:0] {
    RESET   = 6'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    UNKNOWN
  } instr_type;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // funct3 for every mnemonic that has one; everything else reads 0.
  function automatic logic [2:0] funct3_of(input logic [5:0] t);
    logic [2:0] f3;
    f3 = 3'd0;
    case (t)
      BNE, LH, SH, SLLI, SLL, MULH:              f3 = 3'd1;
      LW, SW, SLTI, SLT, MULHSU:                 f3 = 3'd2;
      SLTIU, SLTU, MULHU:                        f3 = 3'd3;
      BLT, LBU, XORI, XOR, DIV:                  f3 = 3'd4;
      BGE, LHU, SRLI, SRAI, SRL, SRA, DIVU:      f3 = 3'd5;
      BLTU, ORI, OR, REM:                        f3 = 3'd6;
      BGEU, ANDI, AND, REMU:                     f3 = 3'd7;
      default:                                   f3 = 3'd0;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/rv32im_instr_encoder.sv
// rv32im_instr_encoder
// Turns one RV32IM instruction request into its 32-bit machine word and
// buffers the result in a 2-entry output FIFO. Requests whose immediate
// does not fit the format (or whose type is unknown) are queued as word 0
// with the illegal flag set, so the consumer sees every request in order.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          request handshake (in_ready = occupancy < 2)
//   in_type, in_rd, in_rs1,
//   in_rs2, in_imm               request fields
//   out_valid / out_ready        result handshake
//   out_instr, out_illegal       queue head (both 0 when empty)
//   instr_count                  output handshakes, wraps
//   illegal_count                illegal entries output, saturates
module rv32im_instr_encoder
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_type,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_illegal,
  output logic [31:0] instr_count,
  output logic [15:0] illegal_count
);

  // ---------------- combinational encoder ----------------
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic [2:0]  f3;

  // Range checks: a value fits N signed bits when every bit above N-1
  // equals the sign bit.
  logic fits12, b_ok, j_ok, shamt_ok, upper_ok;
  assign fits12   = (in_imm[31:11] == {21{in_imm[11]}});
  assign b_ok     = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign j_ok     = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
  assign shamt_ok = (in_imm[31:5] == 27'd0);
  assign upper_ok = (in_imm[11:0] == 12'd0);

  always_comb begin
    enc_word    = 32'd0;
    enc_illegal = 1'b0;
    f3          = funct3_of(in_type);
    case (in_type)
      RESET: enc_word = NOP_WORD;
      LUI: begin
        enc_word    = {in_imm[31:12], in_rd, OP_LUI};
        enc_illegal = !upper_ok;
      end
      AUIPC: begin
        enc_word    = {in_imm[31:12], in_rd, OP_AUIPC};
        enc_illegal = !upper_ok;
      end
      JAL: begin
        enc_word    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_illegal = !j_ok;
      end
      JALR: begin
        enc_word    = {in_imm[11:0], in_rs1, f3, in_rd, OP_JALR};
        enc_illegal = !fits12;
      end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        enc_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                       in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_illegal = !b_ok;
      end
      LB, LH, LW, LBU, LHU: begin
        enc_word    = {in_imm[11:0], in_rs1, f3, in_rd, OP_LOAD};
        enc_illegal = !fits12;
      end
      SB, SH, SW: begin
        enc_word    = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], OP_STORE};
        enc_illegal = !fits12;
      end
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI: begin
        enc_word    = {in_imm[11:0], in_rs1, f3, in_rd, OP_IMM};
        enc_illegal = !fits12;
      end
      SLLI, SRLI: begin
        enc_word    = {7'h00, in_imm[4:0], in_rs1, f3, in_rd, OP_IMM};
        enc_illegal = !shamt_ok;
      end
      SRAI: begin
        enc_word    = {7'h20, in_imm[4:0], in_rs1, f3, in_rd, OP_IMM};
        enc_illegal = !shamt_ok;
      end
      ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND:
        enc_word = {7'h00, in_rs2, in_rs1, f3, in_rd, OP_OP};
      SUB, SRA:
        enc_word = {7'h20, in_rs2, in_rs1, f3, in_rd, OP_OP};
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU:
        enc_word = {7'h01, in_rs2, in_rs1, f3, in_rd, OP_OP};
      default: enc_illegal = 1'b1;
    endcase
    if (enc_illegal) enc_word = 32'd0;
  end

  // ---------------- 2-entry output queue ----------------
  logic [31:0] q_word_reg [2];
  logic        q_ill_reg  [2];
  logic        head_reg, tail_reg;
  logic [1:0]  count_reg;
  logic [31:0] instr_count_reg;
  logic [15:0] illegal_count_reg;
  logic        push, pop;

  // in_ready comes from registered occupancy only, never from out_ready.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_instr     = out_valid ? q_word_reg[head_reg] : 32'd0;
  assign out_illegal   = out_valid ? q_ill_reg[head_reg]  : 1'b0;
  assign instr_count   = instr_count_reg;
  assign illegal_count = illegal_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg          <= 1'b0;
      tail_reg          <= 1'b0;
      count_reg         <= 2'd0;
      instr_count_reg   <= 32'd0;
      illegal_count_reg <= 16'd0;
    end else begin
      if (push) begin
        q_word_reg[tail_reg] <= enc_word;
        q_ill_reg[tail_reg]  <= enc_illegal;
        tail_reg             <= ~tail_reg;
      end
      if (pop) begin
        head_reg        <= ~head_reg;
        instr_count_reg <= instr_count_reg + 32'd1;
        if (q_ill_reg[head_reg] && illegal_count_reg != 16'hFFFF)
          illegal_count_reg <= illegal_count_reg + 16'd1;
      end
      // Push and pop together leave occupancy unchanged.
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule
